rgb_pwm_driver: RTL
===================

# rgb_pwm_driver

Converts the three 8-bit channel intensities from the light controller into per-pin PWM waveforms for the RGB LED. It also generates the `pwm` blink square wave that the controller consumes in its blinking mode. It sits between the controller outputs (`outr`/`outg`/`outb`) and the LED pins. Duty values are double-buffered so that a change never truncates or stretches the period in progress.

## Interface
Parameters:
- `PRESCALE`, default 4: clock cycles per PWM count. Legal range ≥1.
- `BLINK_PERIODS`, default 64: number of PWM periods per half-cycle of `blink`. Legal range ≥1.

Ports:
- `clk`  in  1: single clock. All logic is on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `enable`  in  1: driver run enable; tied to the controller's `on`.
- `duty_r`  in  8: red intensity (from `outr`).
- `duty_g`  in  8: green intensity (from `outg`).
- `duty_b`  in  8: blue intensity (from `outb`).
- `led_r`  out  1: red PWM pin, active-high.
- `led_g`  out  1: green PWM pin, active-high.
- `led_b`  out  1: blue PWM pin, active-high.
- `period_start`  out  1: one-cycle pulse, asserted in the first cycle of each PWM period.
- `blink`  out  1: slow square wave; feeds the controller's `pwm` input.

## Operation
Internal state:
- `pre_cnt`: counts 0..`PRESCALE`-1. `tick` = (`pre_cnt` == `PRESCALE`-1).
- `pwm_cnt`: 8-bit counter. Increments on `tick` and wraps 255→0. One period = 256×`PRESCALE` cycles.
- `wrap` = `tick` && (`pwm_cnt` == 255).
- Active duty registers `act_r/g/b`:
  - Load `duty_*` on `wrap`.
  - Also load continuously while `enable`=0.
  - Hold otherwise. A mid-period change to `duty_*` is ignored until the next period.
- `led_x` <= `enable` && (`pwm_cnt` < `act_x`), registered.
  - duty 0: constantly low.
  - duty 255: low for exactly one count (`PRESCALE` cycles) per period.
  - Comparison is 8-bit unsigned with no saturation logic.
- `period_start` <= `wrap`, registered. It is therefore high in the cycle where `pwm_cnt` first reads 0 and the new `act_*` is visible.
- `blink_cnt`:
  - Counts `wrap` events 0..`BLINK_PERIODS`-1.
  - On the wrap that takes it from `BLINK_PERIODS`-1 back to 0, `blink` toggles.
- While `enable`=0:
  - `pre_cnt`, `pwm_cnt` and `blink_cnt` are held at 0; `blink` is held at 0.
  - All `led_*` = 0; `period_start` = 0.
- `enable` 0→1: counting begins in that cycle with `pwm_cnt`=0, using the `act_*` values loaded during the last disabled cycle.
- `enable` 1→0 mid-period: the next edge forces all outputs low and the counters to 0. No period completion.
- Simultaneous `wrap` and `duty_*` change: the value present on that edge is the one loaded.

## Timing
- Reset values: `led_r`=`led_g`=`led_b`=0, `period_start`=0, `blink`=0. All counters and `act_*` = 0.
- Reset dominates `enable` and applies on the next edge, including mid-period.
- Output latency: `led_x` reflects the `pwm_cnt`/`act_x` of the previous cycle. High time per period is exactly `act_x`×`PRESCALE` cycles, contiguous, starting at the cycle after `period_start` rises.
- Duty update latency: from the duty change to the first cycle using it, at most one full period plus 1 cycle.
- `blink` period: 2×`BLINK_PERIODS`×256×`PRESCALE` cycles. With default parameters this is 131072 cycles.

## Configuration
- Macro: `RGB_PWM_PHASE_EN`.
- Defined:
  - Green compares (`pwm_cnt`+85) mod 256 < `act_g`.
  - Blue compares (`pwm_cnt`+170) mod 256 < `act_b`.
  - Red is unchanged.
  - Effect: the three channels' edges are staggered to spread switching current.
  - High count per period is unchanged, though a channel's pulse may wrap across the period boundary.
- Undefined:
  - All channels compare `pwm_cnt` directly.
  - All rising edges coincide at period start.

## Test plan
- Reset: `reset` high for 2 cycles with `enable`=1 and all duties 0x80 → all outputs 0. After release, `period_start` first pulses 256×`PRESCALE` cycles later.
- `PRESCALE`=1, `enable`=1, `duty_r`=64, `duty_g`=0, `duty_b`=255, steady → per 256-cycle period: `led_r` high 64 contiguous cycles, `led_g` never high, `led_b` high 255 cycles.
- `PRESCALE`=1, `duty_r` changes 64→200 at `pwm_cnt`=10 → current period keeps 64 high cycles; the next period after `period_start` has 200.
- `enable` dropped at `pwm_cnt`=30 with `duty_r`=100 → `led_r` low from the next cycle and counters read 0. When `enable` re-asserts, the full 100-cycle high time restarts from count 0.
- `PRESCALE`=1, `BLINK_PERIODS`=2 → `blink` rises after 512 cycles and falls after 1024, with 4 `period_start` pulses in between.
- `RGB_PWM_PHASE_EN` defined, `PRESCALE`=1, all duties 85 → `led_r` high at counts 0–84. `led_g` high from count 171 of one period through count 255 (85 cycles). `led_b` high from count 86 through count 170 (85 cycles). Each channel has exactly 85 high cycles per period.

Source files
------------

// File: rtl/rgb_pwm_driver.sv
// ----------------------------------------------------------------------------
// rgb_pwm_driver
//
// Turns the three 8-bit channel intensities coming out of the light
// controller into active-high PWM waveforms for the RGB LED pins, and
// produces the slow `blink` square wave the controller uses in its
// blinking mode.
//
// Duty values are double-buffered: the inputs are copied into the active
// registers only at the end of a PWM period (or continuously while the
// driver is disabled), so a duty change never truncates or stretches the
// period that is already running.
//
// Parameters:
//   PRESCALE       clock cycles per PWM count (>= 1)
//   BLINK_PERIODS  PWM periods per half-cycle of blink (>= 1)
//
// Ports:
//   clk           single clock, rising edge
//   reset         synchronous, active-high reset
//   enable        run enable; low holds all counters and outputs at 0
//   duty_r/g/b    8-bit channel intensities
//   led_r/g/b     registered PWM pins, active-high
//   period_start  one-cycle pulse in the first cycle of each PWM period
//   blink         square wave, half period = BLINK_PERIODS PWM periods
//
// Configuration macro:
//   RGB_PWM_PHASE_EN  when defined, green and blue compare against the PWM
//                     count offset by 85 and 170 respectively, staggering
//                     the channel edges to spread switching current.
// ----------------------------------------------------------------------------
module rgb_pwm_driver #(
    parameter int PRESCALE      = 4,
    parameter int BLINK_PERIODS = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] duty_r,
    input  logic [7:0] duty_g,
    input  logic [7:0] duty_b,
    output logic       led_r,
    output logic       led_g,
    output logic       led_b,
    output logic       period_start,
    output logic       blink
);

    // Widths are clamped to at least one bit so PRESCALE=1 and
    // BLINK_PERIODS=1 still give legal (always-zero) counters.
    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int BLK_W = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_PERIODS - 1);

`ifdef RGB_PWM_PHASE_EN
    localparam logic [7:0] PHASE_G = 8'd85;
    localparam logic [7:0] PHASE_B = 8'd170;
`else
    localparam logic [7:0] PHASE_G = 8'd0;
    localparam logic [7:0] PHASE_B = 8'd0;
`endif

    logic [PRE_W-1:0] pre_cnt;
    logic [7:0]       pwm_cnt;
    logic [BLK_W-1:0] blink_cnt;
    logic [7:0]       act_r;
    logic [7:0]       act_g;
    logic [7:0]       act_b;

    logic       tick;
    logic       wrap;
    logic [7:0] cmp_g;
    logic [7:0] cmp_b;

    // A tick advances the PWM count; a wrap is the last tick of a period,
    // which is also the instant the next period's duties are captured.
    // The phase-shifted counts are held in 8-bit nets so the offset wraps
    // modulo 256 rather than growing an extra bit.
    always_comb begin
        tick  = (pre_cnt == PRE_LAST);
        wrap  = tick && (pwm_cnt == 8'd255);
        cmp_g = pwm_cnt + PHASE_G;
        cmp_b = pwm_cnt + PHASE_B;
    end

    // Timebase: prescaler, PWM count and blink divider. All three are held
    // at zero while disabled so that re-enabling always starts a clean,
    // full period from count 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt   <= '0;
            pwm_cnt   <= '0;
            blink_cnt <= '0;
            blink     <= 1'b0;
        end else if (!enable) begin
            pre_cnt   <= '0;
            pwm_cnt   <= '0;
            blink_cnt <= '0;
            blink     <= 1'b0;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
            if (tick) begin
                pwm_cnt <= pwm_cnt + 8'd1;
            end
            if (wrap) begin
                if (blink_cnt == BLK_LAST) begin
                    blink_cnt <= '0;
                    blink     <= ~blink;
                end else begin
                    blink_cnt <= blink_cnt + BLK_W'(1);
                end
            end
        end
    end

    // Active duty buffers. While disabled they track the inputs so the very
    // first period after enable uses the latest intensity; while running
    // they only change on the wrap edge, taking whatever is on the inputs
    // at that edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            act_r <= '0;
            act_g <= '0;
            act_b <= '0;
        end else if (!enable || wrap) begin
            act_r <= duty_r;
            act_g <= duty_g;
            act_b <= duty_b;
        end
    end

    // Registered pin drivers. The plain unsigned compare gives duty 0 as
    // always-off and duty 255 as off for exactly the final count.
    // period_start is the registered wrap, so it lines up with the cycle
    // in which pwm_cnt first reads 0 with the freshly loaded duties.
    always_ff @(posedge clk) begin
        if (reset) begin
            led_r        <= 1'b0;
            led_g        <= 1'b0;
            led_b        <= 1'b0;
            period_start <= 1'b0;
        end else begin
            led_r        <= enable && (pwm_cnt < act_r);
            led_g        <= enable && (cmp_g < act_g);
            led_b        <= enable && (cmp_b < act_b);
            period_start <= enable && wrap;
        end
    end

endmodule
